// File: rtl/bbox_scan_param.sv
// bbox_scan_param: streams an image from a synchronous RAM and reports the bounding box of pixels >= thresh.
// Optional macro BBOX_PIXCOUNT_EN adds a foreground pixel count output.
module bbox_scan_param #(
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int PIX_W  = 8,
  parameter int RD_LAT = 1,
  localparam int X_W    = $clog2(IMG_W),
  localparam int Y_W    = $clog2(IMG_H),
  localparam int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  thresh,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [X_W-1:0]    xMin,
  output logic [X_W-1:0]    xMax,
  output logic [Y_W-1:0]    yMin,
  output logic [Y_W-1:0]    yMax
`ifdef BBOX_PIXCOUNT_EN
  ,
  output logic [ADDR_W:0]   pix_count
`endif
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t state;
  logic [X_W-1:0] x, rx_min, rx_max;
  logic [Y_W-1:0] y, ry_min, ry_max;
  logic [PIX_W-1:0] th_q;
  logic [2:0] dcnt;
  logic [RD_LAT-1:0][X_W-1:0] px;
  logic [RD_LAT-1:0][Y_W-1:0] py;
  logic [RD_LAT-1:0] pv;
  logic hit, x_last, a_last;
`ifdef BBOX_PIXCOUNT_EN
  logic [ADDR_W:0] cnt_run;
`endif
  always_comb begin
    hit = pv[RD_LAT-1] && (rd_data >= th_q);
    x_last = x == X_W'(IMG_W-1);
    a_last = rd_addr == ADDR_W'(IMG_W*IMG_H-1);
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state <= IDLE;
      rd_addr <= '0;
      rd_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      found <= 1'b0;
      xMin <= '0;
      xMax <= '0;
      yMin <= '0;
      yMax <= '0;
      x <= '0;
      y <= '0;
      rx_min <= '0;
      rx_max <= '0;
      ry_min <= '0;
      ry_max <= '0;
      th_q <= '0;
      dcnt <= '0;
      px <= '0;
      py <= '0;
      pv <= '0;
`ifdef BBOX_PIXCOUNT_EN
      cnt_run <= '0;
      pix_count <= '0;
`endif
    end else begin
      for (int i = RD_LAT-1; i > 0; i--) begin
        px[i] <= px[i-1];
        py[i] <= py[i-1];
        pv[i] <= pv[i-1];
      end
      px[0] <= x;
      py[0] <= y;
      pv[0] <= rd_en;
      if (hit) begin
        found <= 1'b1;
        rx_min <= px[RD_LAT-1] < rx_min ? px[RD_LAT-1] : rx_min;
        rx_max <= px[RD_LAT-1] > rx_max ? px[RD_LAT-1] : rx_max;
        ry_min <= py[RD_LAT-1] < ry_min ? py[RD_LAT-1] : ry_min;
        ry_max <= py[RD_LAT-1] > ry_max ? py[RD_LAT-1] : ry_max;
`ifdef BBOX_PIXCOUNT_EN
        cnt_run <= cnt_run + 1'b1;
`endif
      end
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= SCAN;
            th_q <= thresh;
            x <= '0;
            y <= '0;
            rd_addr <= '0;
            rd_en <= 1'b1;
            busy <= 1'b1;
            done <= 1'b0;
            found <= 1'b0;
            rx_min <= X_W'(IMG_W-1);
            ry_min <= Y_W'(IMG_H-1);
            rx_max <= '0;
            ry_max <= '0;
`ifdef BBOX_PIXCOUNT_EN
            cnt_run <= '0;
`endif
          end
        SCAN:
          if (a_last) begin
            state <= DRAIN;
            rd_en <= 1'b0;
            dcnt <= '0;
          end else begin
            rd_addr <= rd_addr + 1'b1;
            x <= x_last ? '0 : x + 1'b1;
            y <= x_last ? y + 1'b1 : y;
          end
        default:
          // the last pixel reaches the running registers one edge before publishing
          if (dcnt == 3'(RD_LAT)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            xMin <= found ? rx_min : '0;
            xMax <= found ? rx_max : '0;
            yMin <= found ? ry_min : '0;
            yMax <= found ? ry_max : '0;
`ifdef BBOX_PIXCOUNT_EN
            pix_count <= cnt_run;
`endif
          end else dcnt <= dcnt + 1'b1;
      endcase
    end
endmodule

// File: tb/tb_bbox_scan_param.sv
// tb_bbox_scan_param: table-driven and randomized checks of bbox_scan_param on a 100x100 and a 16x8 instance.
module tb_bbox_scan_param;
  localparam int NA = 10000;
  localparam int NB = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;

  logic start_a = 1'b0, start_b = 1'b0;
  logic [7:0] th_a = '0, th_b = '0;
  logic [13:0] addr_a;
  logic [6:0] addr_b;
  logic en_a, en_b, busy_a, busy_b, done_a, done_b, found_a, found_b;
  logic [7:0] rdat_a, rdat_b;
  logic [6:0] xmin_a, xmax_a, ymin_a, ymax_a;
  logic [3:0] xmin_b, xmax_b;
  logic [2:0] ymin_b, ymax_b;
`ifdef BBOX_PIXCOUNT_EN
  logic [14:0] pc_a;
  logic [7:0] pc_b;
`endif

  bbox_scan_param u_a (
    .CLOCK_50(clk), .reset(rst), .start(start_a), .thresh(th_a),
    .rd_addr(addr_a), .rd_en(en_a), .rd_data(rdat_a),
    .busy(busy_a), .done(done_a), .found(found_a),
    .xMin(xmin_a), .xMax(xmax_a), .yMin(ymin_a), .yMax(ymax_a)
`ifdef BBOX_PIXCOUNT_EN
    , .pix_count(pc_a)
`endif
  );

  bbox_scan_param #(.IMG_W(16), .IMG_H(8), .PIX_W(8), .RD_LAT(3)) u_b (
    .CLOCK_50(clk), .reset(rst), .start(start_b), .thresh(th_b),
    .rd_addr(addr_b), .rd_en(en_b), .rd_data(rdat_b),
    .busy(busy_b), .done(done_b), .found(found_b),
    .xMin(xmin_b), .xMax(xmax_b), .yMin(ymin_b), .yMax(ymax_b)
`ifdef BBOX_PIXCOUNT_EN
    , .pix_count(pc_b)
`endif
  );

  // RAM models: latency 1 for the large image, latency 3 for the small one
  logic [7:0] mem_a [NA];
  logic [7:0] mem_b [NB];
  logic [7:0] pb [3];
  always @(posedge clk) begin
    rdat_a <= mem_a[addr_a];
    pb[0] <= mem_b[addr_b];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign rdat_b = pb[2];

  typedef struct {
    int img;
    int th;
    int f, x0, y0, x1, y1, cnt;
  } vec_t;
  vec_t tv [6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_a(input int img);
    for (int y = 0; y < 100; y++)
      for (int x = 0; x < 100; x++) begin
        int v;
        case (img)
          0: v = (x >= 28 && x <= 79 && y >= 29 && y <= 65) ? 1 : 0;
          1: v = (x == 99 && y == 99) ? 1 : 0;
          2: v = (x == 0 && y == 0) ? 1 : 0;
          4: v = x;
          5: v = 1;
          default: v = 0;
        endcase
        mem_a[y*100+x] = 8'(v);
      end
  endtask

  task automatic run_a(input int th, input int abort_at, output int lat);
    @(negedge clk);
    start_a = 1'b1;
    th_a = 8'(th);
    @(posedge clk);
    #1 start_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 12000 && lat != abort_at) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic run_b(input int th, input int pulse_at, output int lat);
    @(negedge clk);
    start_b = 1'b1;
    th_b = 8'(th);
    @(posedge clk);
    #1 start_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 500) begin
      if (lat == pulse_at) begin
        start_b = 1'b1;
        th_b = 8'hff;
        chk("busy_mid_b", int'(busy_b), 1);
      end
      @(posedge clk);
      #1 start_b = 1'b0;
      lat++;
    end
  endtask

  task automatic chk_a(input string tag, input int f, input int x0, input int y0, input int x1, input int y1);
    chk({tag, "_found"}, int'(found_a), f);
    chk({tag, "_xmin"}, int'(xmin_a), x0);
    chk({tag, "_ymin"}, int'(ymin_a), y0);
    chk({tag, "_xmax"}, int'(xmax_a), x1);
    chk({tag, "_ymax"}, int'(ymax_a), y1);
  endtask

  task automatic chk_b(input string tag, input int f, input int x0, input int y0, input int x1, input int y1);
    chk({tag, "_found"}, int'(found_b), f);
    chk({tag, "_xmin"}, int'(xmin_b), x0);
    chk({tag, "_ymin"}, int'(ymin_b), y0);
    chk({tag, "_xmax"}, int'(xmax_b), x1);
    chk({tag, "_ymax"}, int'(ymax_b), y1);
  endtask

  initial begin
    int lat;
    tv[0] = '{0, 1, 1, 28, 29, 79, 65, 1924};
    tv[1] = '{1, 1, 1, 99, 99, 99, 99, 1};
    tv[2] = '{2, 1, 1, 0, 0, 0, 0, 1};
    tv[3] = '{3, 1, 0, 0, 0, 0, 0, 0};
    tv[4] = '{4, 50, 1, 50, 0, 99, 99, 5000};
    tv[5] = '{5, 0, 1, 0, 0, 99, 99, 10000};
    for (int i = 0; i < NB; i++) mem_b[i] = 8'd0;
    fill_a(3);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", int'(done_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_en", int'(en_a), 0);
    chk("rst_found", int'(found_a), 0);
    @(negedge clk) rst = 1'b0;

    // Large image: table vectors run back to back
    for (int i = 0; i < 6; i++) begin
      fill_a(tv[i].img);
      run_a(tv[i].th, -1, lat);
      chk($sformatf("v%0d_lat", i), lat, 10002);
      chk_a($sformatf("v%0d", i), tv[i].f, tv[i].x0, tv[i].y0, tv[i].x1, tv[i].y1);
`ifdef BBOX_PIXCOUNT_EN
      chk($sformatf("v%0d_cnt", i), int'(pc_a), tv[i].cnt);
`endif
    end

    // Reset in the middle of a scan, then a clean rescan
    fill_a(0);
    run_a(1, 500, lat);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy_a), 0);
    chk("mid_rst_addr", int'(addr_a), 0);
    chk("mid_rst_en", int'(en_a), 0);
    chk_a("mid_rst", 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    run_a(1, -1, lat);
    chk("rescan_lat", lat, 10002);
    chk_a("rescan", 1, 28, 29, 79, 65);

    // Small image, RD_LAT=3: two pixels, ignored start pulse with a different threshold
    mem_b[2*16+3] = 8'd9;
    mem_b[5*16+12] = 8'd200;
    run_b(9, 40, lat);
    chk("b_lat", lat, 132);
    chk_b("b_two", 1, 3, 2, 12, 5);
`ifdef BBOX_PIXCOUNT_EN
    chk("b_two_cnt", int'(pc_b), 2);
`endif

    // Start held high in DONE restarts immediately; done lasts one cycle
    @(negedge clk) start_b = 1'b1;
    lat = 0;
    while (!done_b && lat < 500) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("hold_done", int'(done_b), 1);
    @(posedge clk);
    #1;
    chk("hold_done_drop", int'(done_b), 0);
    chk("hold_busy", int'(busy_b), 1);
    start_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 500) begin
      @(posedge clk);
      #1 lat++;
    end

    // Randomized small images against a box/count reference
    for (int it = 0; it < 20; it++) begin
      int th, f, x0, y0, x1, y1, c;
      th = (it == 0) ? 0 : int'($urandom_range(1, 255));
      for (int i = 0; i < NB; i++) mem_b[i] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'd0;
      f = 0; x0 = 15; y0 = 7; x1 = 0; y1 = 0; c = 0;
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 16; x++)
          if (int'(mem_b[y*16+x]) >= th) begin
            f = 1; c++;
            if (x < x0) x0 = x;
            if (x > x1) x1 = x;
            if (y < y0) y0 = y;
            if (y > y1) y1 = y;
          end
      if (f == 0) begin
        x0 = 0; y0 = 0; x1 = 0; y1 = 0;
      end
      run_b(th, -1, lat);
      chk($sformatf("r%0d_lat", it), lat, 132);
      chk_b($sformatf("r%0d", it), f, x0, y0, x1, y1);
`ifdef BBOX_PIXCOUNT_EN
      chk($sformatf("r%0d_cnt", it), int'(pc_b), c);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
